// File: rtl/lcd_power_sequencer.sv
// lcd_power_sequencer
//
// Power/enable sequencer for the 800x480 RGB LCD path. On request it raises the panel
// supply, releases the timing generator, keeps the RGB bus blanked for the first frames,
// and then enables the backlight. Disable or a frame-watchdog fault runs the reverse
// sequence. The watchdog monitors vs from the timing generator.
//
// Optional feature macro: LCD_BL_PWM_EN (adds bl_duty input and bl_pwm output).
//
// Ports:
//   clk        in   pixel clock
//   rst        in   synchronous reset, active-high
//   en         in   level request, 1 = display on
//   fault_clr  in   clears the sticky fault, honoured only in OFF
//   vs         in   vertical sync from the timing generator
//   bl_duty    in   [7:0] backlight PWM duty (LCD_BL_PWM_EN only)
//   bl_pwm     out  backlight PWM (LCD_BL_PWM_EN only)
//   lcd_pwr_en out  panel supply enable
//   timing_rst out  holds the timing generator in reset while high
//   disp_en    out  panel DISP pin
//   blank      out  forces RGB to zero while high
//   bl_en      out  backlight enable
//   ready      out  high only in RUN
//   fault      out  sticky watchdog fault
//   state      out  [2:0] current state encoding

module lcd_power_sequencer #(
    parameter int unsigned T_PWR_CYC    = 33000,
    parameter int unsigned BLANK_FRAMES = 2,
    parameter int unsigned T_BL_CYC     = 330000,
    parameter int unsigned T_OFF_CYC    = 33000,
    parameter int unsigned FRAME_TO_CYC = 1000000,
    parameter logic        VS_POL       = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       fault_clr,
    input  logic       vs,
`ifdef LCD_BL_PWM_EN
    input  logic [7:0] bl_duty,
    output logic       bl_pwm,
`endif
    output logic       lcd_pwr_en,
    output logic       timing_rst,
    output logic       disp_en,
    output logic       blank,
    output logic       bl_en,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StOff      = 3'd0,
        StPwrUp    = 3'd1,
        StSyncWait = 3'd2,
        StBlank    = 3'd3,
        StBlDelay  = 3'd4,
        StRun      = 3'd5,
        StBlOff    = 3'd6,
        StPwrDown  = 3'd7
    } state_e;

    localparam logic [19:0] PwrLast   = 20'(T_PWR_CYC - 1);
    localparam logic [19:0] BlLast    = 20'(T_BL_CYC - 1);
    localparam logic [19:0] OffLast   = 20'(T_OFF_CYC - 1);
    localparam logic [19:0] WdLast    = 20'(FRAME_TO_CYC - 1);
    localparam logic [7:0]  FrameLast = 8'(BLANK_FRAMES - 1);

    state_e      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [19:0] wd_q, wd_d;
    logic [7:0]  frame_q, frame_d;
    logic        fault_d;
    logic        vs_q;
    logic        tick;
    logic        watched;
    logic        wd_expired;
    logic        pwr_d, trst_d, disp_d, blank_d, bl_d, ready_d;

    always_ff @(posedge clk) begin
        vs_q <= vs;
    end

    // One-cycle pulse on entry into the active vs level.
    assign tick = (vs_q != VS_POL) && (vs == VS_POL);

    // The watchdog only runs while the timing generator is released and frames are expected.
    assign watched    = state_q inside {StSyncWait, StBlank, StBlDelay, StRun};
    // A tick in the last allowed cycle still counts as on time.
    assign wd_expired = watched && !tick && (wd_q == WdLast);

    always_comb begin
        state_d = state_q;
        fault_d = fault;
        frame_d = frame_q;

        case (state_q)
            StOff: begin
                // Clear takes priority; a pending en is acted on the following cycle.
                if (fault_clr) begin
                    fault_d = 1'b0;
                end else if (en && !fault) begin
                    state_d = StPwrUp;
                end
            end
            StPwrUp: begin
                if (!en) begin
                    state_d = StPwrDown;
                end else if (cnt_q == PwrLast) begin
                    state_d = StSyncWait;
                end
            end
            StSyncWait: begin
                if (wd_expired) begin
                    fault_d = 1'b1;
                    state_d = StPwrDown;
                end else if (!en) begin
                    state_d = StPwrDown;
                end else if (tick) begin
                    state_d = StBlank;
                    frame_d = 8'd0;
                end
            end
            StBlank: begin
                if (wd_expired) begin
                    fault_d = 1'b1;
                    state_d = StPwrDown;
                end else if (!en) begin
                    state_d = StPwrDown;
                end else if (tick) begin
                    frame_d = frame_q + 8'd1;
                    if (frame_q == FrameLast) begin
                        state_d = StBlDelay;
                    end
                end
            end
            StBlDelay: begin
                if (wd_expired) begin
                    fault_d = 1'b1;
                    state_d = StPwrDown;
                end else if (!en) begin
                    state_d = StPwrDown;
                end else if (cnt_q == BlLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (wd_expired) begin
                    fault_d = 1'b1;
                    state_d = StBlOff;
                end else if (!en) begin
                    state_d = StBlOff;
                end
            end
            StBlOff: begin
                if (cnt_q == BlLast) begin
                    state_d = StPwrDown;
                end
            end
            StPwrDown: begin
                if (cnt_q == OffLast) begin
                    state_d = StOff;
                end
            end
            default: state_d = StOff;
        endcase
    end

    // Cycle counter restarts on every state entry and saturates rather than wrapping.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = 20'd0;
        end else if (cnt_q == 20'hFFFFF) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 20'd1;
        end

        if (!watched || tick) begin
            wd_d = 20'd0;
        end else if (wd_q == 20'hFFFFF) begin
            wd_d = wd_q;
        end else begin
            wd_d = wd_q + 20'd1;
        end
    end

    // Outputs are a pure function of the state being entered, registered with it.
    always_comb begin
        pwr_d   = 1'b1;
        trst_d  = 1'b0;
        disp_d  = 1'b1;
        blank_d = 1'b1;
        bl_d    = 1'b0;
        ready_d = 1'b0;
        case (state_d)
            StOff: begin
                pwr_d  = 1'b0;
                trst_d = 1'b1;
                disp_d = 1'b0;
            end
            StPwrUp, StPwrDown: begin
                trst_d = 1'b1;
                disp_d = 1'b0;
            end
            StBlDelay: begin
                blank_d = 1'b0;
            end
            StRun: begin
                blank_d = 1'b0;
                bl_d    = 1'b1;
                ready_d = 1'b1;
            end
            default: begin
                // SYNC_WAIT, BLANK and BL_OFF use the defaults above.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StOff;
            cnt_q      <= 20'd0;
            wd_q       <= 20'd0;
            frame_q    <= 8'd0;
            fault      <= 1'b0;
            lcd_pwr_en <= 1'b0;
            timing_rst <= 1'b1;
            disp_en    <= 1'b0;
            blank      <= 1'b1;
            bl_en      <= 1'b0;
            ready      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wd_q       <= wd_d;
            frame_q    <= frame_d;
            fault      <= fault_d;
            lcd_pwr_en <= pwr_d;
            timing_rst <= trst_d;
            disp_en    <= disp_d;
            blank      <= blank_d;
            bl_en      <= bl_d;
            ready      <= ready_d;
        end
    end

    assign state = state_q;

`ifdef LCD_BL_PWM_EN
    logic [7:0] pwm_cnt_q;
    logic [7:0] duty_q;

    // Duty is only picked up at the period boundary so a period is never truncated.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q <= 8'd0;
            duty_q    <= 8'd0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            if (pwm_cnt_q == 8'hFF) begin
                duty_q <= bl_duty;
            end
        end
    end

    assign bl_pwm = bl_en && (pwm_cnt_q < duty_q);
`endif

endmodule

// File: tb/tb_lcd_power_sequencer.sv
module tb_lcd_power_sequencer;

    localparam int T_PWR  = 4;
    localparam int NBLANK = 2;
    localparam int T_BL   = 8;
    localparam int T_OFF  = 4;
    localparam int WD     = 100;
    localparam logic VSP  = 1'b0;

    localparam int P_OFF = 0, P_UP = 1, P_SYNC = 2, P_BLANK = 3;
    localparam int P_BLDLY = 4, P_RUN = 5, P_BLOFF = 6, P_DOWN = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic fault_clr = 1'b0;
    logic vs = 1'b1;
    logic lcd_pwr_en, timing_rst, disp_en, blank, bl_en, ready, fault;
    logic [2:0] state;
`ifdef LCD_BL_PWM_EN
    logic [7:0] bl_duty = 8'd0;
    logic bl_pwm;
`endif

    lcd_power_sequencer #(
        .T_PWR_CYC   (T_PWR),
        .BLANK_FRAMES(NBLANK),
        .T_BL_CYC    (T_BL),
        .T_OFF_CYC   (T_OFF),
        .FRAME_TO_CYC(WD),
        .VS_POL      (VSP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fault_clr (fault_clr),
        .vs        (vs),
`ifdef LCD_BL_PWM_EN
        .bl_duty   (bl_duty),
        .bl_pwm    (bl_pwm),
`endif
        .lcd_pwr_en(lcd_pwr_en),
        .timing_rst(timing_rst),
        .disp_en   (disp_en),
        .blank     (blank),
        .bl_en     (bl_en),
        .ready     (ready),
        .fault     (fault),
        .state     (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // vs source: one pulse of vs_low active cycles every vs_period clocks; 0 = stuck inactive.
    int vs_period = 40;
    int vs_low = 1;
    int vs_ph = 0;
    always @(posedge clk) begin
        #1;
        if (vs_period == 0) begin
            vs = ~VSP;
        end else begin
            vs_ph = (vs_ph + 1) % vs_period;
            vs = (vs_ph < vs_low) ? VSP : ~VSP;
        end
    end

    // Reference model: phase + timestamps of phase entry and of the last frame tick.
    // Expected {lcd_pwr_en, timing_rst, disp_en, blank, bl_en, ready} per phase.
    logic [5:0] out_tab [8] = '{6'b010100, 6'b110100, 6'b101100, 6'b101100,
                                6'b101000, 6'b101011, 6'b101100, 6'b110100};
    int   ph = P_OFF;
    int   now = 0;
    int   t_enter = 0;
    int   t_wd = 0;
    int   nframes = 0;
    int   nxt;
    bit   m_fault = 1'b0;
    bit   m_valid = 1'b0;
    bit   m_tick, m_watch, m_exp;
    logic prev_vs = 1'b1;
`ifdef LCD_BL_PWM_EN
    int pwm_n = 0;
    int duty_m = 0;
`endif

    always @(posedge clk) begin
        if (rst) begin
            ph      = P_OFF;
            m_fault = 1'b0;
            t_enter = now + 1;
            t_wd    = now + 1;
            m_valid = 1'b1;
`ifdef LCD_BL_PWM_EN
            pwm_n  = 0;
            duty_m = 0;
`endif
        end else begin
            m_tick  = (prev_vs != VSP) && (vs == VSP);
            m_watch = ph inside {P_SYNC, P_BLANK, P_BLDLY, P_RUN};
            m_exp   = m_watch && !m_tick && (now - t_wd == WD - 1);
            nxt = ph;
            case (ph)
                P_OFF: begin
                    if (fault_clr) m_fault = 1'b0;
                    else if (en && !m_fault) nxt = P_UP;
                end
                P_UP: begin
                    if (!en) nxt = P_DOWN;
                    else if (now - t_enter == T_PWR - 1) nxt = P_SYNC;
                end
                P_SYNC, P_BLANK, P_BLDLY: begin
                    if (m_exp) begin
                        m_fault = 1'b1;
                        nxt = P_DOWN;
                    end else if (!en) begin
                        nxt = P_DOWN;
                    end else if (ph == P_SYNC && m_tick) begin
                        nxt = P_BLANK;
                        nframes = 0;
                    end else if (ph == P_BLANK && m_tick) begin
                        if (nframes == NBLANK - 1) nxt = P_BLDLY;
                        else nframes++;
                    end else if (ph == P_BLDLY && now - t_enter == T_BL - 1) begin
                        nxt = P_RUN;
                    end
                end
                P_RUN: begin
                    if (m_exp) begin
                        m_fault = 1'b1;
                        nxt = P_BLOFF;
                    end else if (!en) begin
                        nxt = P_BLOFF;
                    end
                end
                P_BLOFF: if (now - t_enter == T_BL - 1) nxt = P_DOWN;
                default: if (now - t_enter == T_OFF - 1) nxt = P_OFF;
            endcase
            if (nxt != ph) t_enter = now + 1;
            if (m_tick || !m_watch) t_wd = now + 1;
            ph = nxt;
`ifdef LCD_BL_PWM_EN
            if (pwm_n == 255) duty_m = int'(bl_duty);
            pwm_n = (pwm_n + 1) % 256;
`endif
        end
        prev_vs = vs;
        now++;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("outputs", {22'd0, lcd_pwr_en, timing_rst, disp_en, blank, bl_en, ready, fault, state},
                {22'd0, out_tab[ph], m_fault, 3'(ph)});
`ifdef LCD_BL_PWM_EN
            chk("bl_pwm", {31'd0, bl_pwm}, {31'd0, (ph == P_RUN) && (pwm_n < duty_m)});
`endif
        end
    end

    function automatic logic pick(input int sel);
        case (sel)
            0: return lcd_pwr_en;
            1: return timing_rst;
            2: return disp_en;
            3: return blank;
            4: return bl_en;
            5: return ready;
            6: return fault;
            7: return state == 3'd3;
            8: return state == 3'd0;
            9: return state == 3'd6;
            default: return 1'bx;
        endcase
    endfunction

    // Called at a negedge; counts negedges until the selected signal reaches val.
    task automatic wait_for(input string nm, input int sel, input logic val, input int budget,
                            output int n);
        n = 0;
        while (pick(sel) !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (pick(sel) !== val) begin
            total++;
            bad++;
            $display("FAIL %s: timeout after %0d cycles, got %b want %b", nm, n, pick(sel), val);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_values", {22'd0, lcd_pwr_en, timing_rst, disp_en, blank, bl_en, ready, fault, state},
            32'b0101000000);
        rst = 1'b0;
        @(negedge clk);

        // Power-up.
        en = 1'b1;
        wait_for("pwr_rise", 0, 1'b1, 5, n);   chk("pwr_rise_lat", n, 1);
        wait_for("trst_fall", 1, 1'b0, 10, n); chk("trst_fall_lat", n, 4);
        chk("disp_with_trst", {31'd0, disp_en}, 1);
        wait_for("blank_state", 7, 1'b1, 100, n);
        wait_for("blank_fall", 3, 1'b0, 200, n); chk("blank_frames", n, 80);
        wait_for("bl_rise", 4, 1'b1, 20, n);     chk("bl_rise_lat", n, 8);
        chk("ready_run", {31'd0, ready}, 1);
        chk("state_run", {29'd0, state}, 5);

        // Power-down from RUN.
        en = 1'b0;
        wait_for("bl_fall", 4, 1'b0, 5, n);    chk("bl_fall_lat", n, 1);
        chk("blank_on_bl_off", {31'd0, blank}, 1);
        wait_for("disp_fall", 2, 1'b0, 20, n); chk("disp_fall_lat", n, 8);
        chk("trst_on_down", {31'd0, timing_rst}, 1);
        wait_for("pwr_fall", 0, 1'b0, 20, n);  chk("pwr_fall_lat", n, 4);
        chk("state_off", {29'd0, state}, 0);

        // Watchdog from RUN with vs stuck inactive.
        en = 1'b1;
        wait_for("bl_rise2", 4, 1'b1, 400, n);
        n = 0;
        while (vs !== VSP && n < 100) begin
            @(negedge clk);
            n++;
        end
        vs_period = 0;
        wait_for("wd_fault", 6, 1'b1, 200, n); chk("wd_latency", n, 101);
        chk("wd_bl_off", {31'd0, bl_en}, 0);
        wait_for("wd_off", 8, 1'b1, 50, n);    chk("wd_down_len", n, 12);
        vs_period = 40;
        repeat (10) @(negedge clk);
        chk("fault_blocks_en", {28'd0, fault, state}, 32'h8);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("clear_stays_off", {28'd0, fault, state}, 0);
        @(negedge clk);
        chk("restart_after_clr", {29'd0, state}, 1);

        // Abort during BLANK.
        wait_for("reach_blank", 7, 1'b1, 200, n);
        en = 1'b0;
        @(negedge clk);
        chk("abort_pwr_down", {29'd0, state}, 7);
        chk("abort_blank", {31'd0, blank}, 1);
        wait_for("abort_pwr_fall", 0, 1'b0, 20, n); chk("abort_pwr_fall_lat", n, 4);

        // en re-asserted during BL_OFF.
        en = 1'b1;
        wait_for("bl_rise3", 4, 1'b1, 400, n);
        en = 1'b0;
        @(negedge clk);
        chk("bl_off_entry", {29'd0, state}, 6);
        en = 1'b1;
        wait_for("toggle_off", 8, 1'b1, 50, n); chk("toggle_down_len", n, 12);
        @(negedge clk);
        chk("toggle_restart", {29'd0, state}, 1);

        // Randomized segments checked by the model.
        for (int seg = 0; seg < 60; seg++) begin
            int hold;
            en = ($urandom_range(0, 3) != 0);
            hold = $urandom_range(1, 300);
            if ($urandom_range(0, 5) == 0) vs_period = 0;
            else vs_period = $urandom_range(20, 130);
            vs_low = $urandom_range(1, 3);
`ifdef LCD_BL_PWM_EN
            bl_duty = 8'($urandom_range(0, 255));
`endif
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                fault_clr = ($urandom_range(0, 19) == 0);
                rst = ($urandom_range(0, 999) == 0);
            end
        end
        fault_clr = 1'b0;
        rst = 1'b0;

`ifdef LCD_BL_PWM_EN
        rst = 1'b1;
        vs_period = 40;
        vs_low = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bl_duty = 8'd64;
        en = 1'b1;
        wait_for("pwm_run", 4, 1'b1, 400, n);
        repeat (300) @(negedge clk);
        n = 0;
        for (int k = 0; k < 512; k++) begin
            if (bl_pwm === 1'b1) n++;
            @(negedge clk);
        end
        chk("pwm_high_count", n, 128);
        bl_duty = 8'd200;
        repeat (600) @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_power_sequencer.md
Name: lcd_power_sequencer

Overview:
Power/enable sequencer for the 800x480 RGB LCD path.
- Brings up panel supply, releases the timing generator, blanks the first frames, then enables backlight.
- Runs the reverse sequence on disable or fault.
- Watches the timing generator's vs output as a frame watchdog.
- Sits between board control logic and the pixel-timing/pattern datapath, driving its reset and blanking.

Parameters:
T_PWR_CYC, 33000, clocks from lcd_pwr_en rise to timing release (1 ms at 33 MHz)
BLANK_FRAMES, 2, complete frames output blanked after first sync
T_BL_CYC, 330000, clocks between blank release and bl_en rise, and between bl_en fall and timing stop
T_OFF_CYC, 33000, clocks between timing stop and lcd_pwr_en fall
FRAME_TO_CYC, 1000000, watchdog: max clocks between frame ticks
VS_POL, 1'b0, active level of vs

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
en  in  1  level request: 1 = display on, 0 = off
fault_clr  in  1  clears sticky fault; honoured only in OFF
vs  in  1  vertical sync from timing generator
lcd_pwr_en  out  1  panel supply enable
timing_rst  out  1  holds timing generator in reset (high = held)
disp_en  out  1  panel DISP pin
blank  out  1  forces RGB to zero when high
bl_en  out  1  backlight enable
ready  out  1  high only in RUN
fault  out  1  sticky watchdog fault
state  out  3  current state encoding

Behaviour:
- Reset is synchronous and active-high. Reset values: state=OFF, lcd_pwr_en=0, timing_rst=1, disp_en=0, blank=1, bl_en=0, ready=0, fault=0. All counters are 0.
- All outputs are registered and change on the same edge as the state register.
- Frame tick: vs_d is vs registered. tick=1 for one cycle when vs_d!=VS_POL && vs==VS_POL.
- State encoding: OFF=0, PWR_UP=1, SYNC_WAIT=2, BLANK=3, BL_DELAY=4, RUN=5, BL_OFF=6, PWR_DOWN=7.
- Every state entry clears the cycle counter.
- OFF:
  - en=1 && fault=0 -> PWR_UP; lcd_pwr_en<=1.
  - fault_clr=1 -> fault<=0. If fault_clr and en are both high, clear first; leave OFF on the next cycle.
- PWR_UP:
  - cnt==T_PWR_CYC-1 -> SYNC_WAIT; timing_rst<=0, disp_en<=1.
  - en=0 -> PWR_DOWN.
- SYNC_WAIT:
  - tick -> BLANK; frame_cnt<=0.
  - Watchdog cnt==FRAME_TO_CYC-1 -> fault<=1, go to PWR_DOWN.
  - en=0 -> PWR_DOWN.
- BLANK:
  - Each tick increments frame_cnt and clears the watchdog.
  - On tick with frame_cnt==BLANK_FRAMES-1 -> BL_DELAY; blank<=0, aligned to the frame-sync edge.
  - Watchdog expiry -> fault, PWR_DOWN.
  - en=0 -> PWR_DOWN.
- BL_DELAY:
  - cnt==T_BL_CYC-1 -> RUN; bl_en<=1, ready<=1.
  - en=0 -> PWR_DOWN with blank<=1.
  - Watchdog stays active; it is a separate counter cleared on tick.
- RUN:
  - en=0 -> BL_OFF.
  - Watchdog expiry -> fault<=1, BL_OFF.
  - On entry to BL_OFF: bl_en<=0, ready<=0, blank<=1.
- BL_OFF:
  - cnt==T_BL_CYC-1 -> PWR_DOWN; disp_en<=0, timing_rst<=1.
  - en ignored.
- PWR_DOWN:
  - On entry from early states: blank=1, disp_en=0, timing_rst=1.
  - cnt==T_OFF_CYC-1 -> OFF; lcd_pwr_en<=0.
  - en ignored.
- Down sequence is non-abortable. Re-assertion of en is evaluated only once back in OFF.
- Simultaneous en=0 and watchdog expiry: fault is set, and the same next state is taken.
- Counters: cycle counter is 20-bit and saturates (no wrap). Watchdog is 20-bit. frame_cnt is 8-bit.
- rst mid-sequence forces the reset values immediately. The panel supply drops without ordering; this is accepted.

Optional Feature:
LCD_BL_PWM_EN
- Defined:
  - Adds input bl_duty[7:0] and output bl_pwm.
  - 8-bit free-running pwm_cnt increments every clock.
  - bl_duty is sampled into a duty register when pwm_cnt==255.
  - bl_pwm = bl_en && (pwm_cnt < duty_reg): duty 0 gives constant 0, duty 255 gives 255/256 high.
  - bl_pwm resets to 0.
- Undefined: ports bl_duty/bl_pwm are absent. bl_en is the only backlight control.

Test Plan:
(sim params: T_PWR_CYC=4, BLANK_FRAMES=2, T_BL_CYC=8, T_OFF_CYC=4, FRAME_TO_CYC=100; vs pulse low every 40 clocks)
- Power-up: rst 3 cycles, then en=1 -> lcd_pwr_en rises at once; timing_rst falls 4 clocks later; blank falls on the 2nd vs falling-edge tick after the first; bl_en and ready rise 8 clocks after that; state=5.
- Power-down from RUN: en=0 -> bl_en=0 and blank=1 next edge; disp_en=0 and timing_rst=1 8 clocks later; lcd_pwr_en=0 4 clocks after that; state=0.
- Watchdog: in RUN, hold vs=1 -> fault=1 after 100 clocks without tick, followed by the full down sequence. In OFF, en=1 is ignored until a fault_clr pulse; then PWR_UP is entered the next cycle.
- Abort: en=0 during BLANK -> PWR_DOWN immediately; bl_en never rises; lcd_pwr_en falls 4 clocks later.
- en toggle 0->1 during BL_OFF -> sequence completes to OFF, then restarts PWR_UP one cycle later.
- With LCD_BL_PWM_EN defined and bl_duty=64 in RUN -> bl_pwm high 64 of every 256 clocks. bl_duty changed mid-period takes effect only after pwm_cnt wraps.
